// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: bit positions, the hex glyph table and the pattern type.
// Used by both the binary-to-segment encoder and the segment-to-binary decoder.
package seg7_pkg;

  typedef logic [7:0] seg_t;

  localparam int SEG_A  = 6;
  localparam int SEG_B  = 5;
  localparam int SEG_C  = 4;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 2;
  localparam int SEG_F  = 1;
  localparam int SEG_G  = 0;
  localparam int SEG_DP = 7;

  // Glyphs are stored with dp cleared; only bits 6..0 identify a digit.
  localparam seg_t GLYPH_0 = 8'h7E;
  localparam seg_t GLYPH_1 = 8'h30;
  localparam seg_t GLYPH_2 = 8'h6D;
  localparam seg_t GLYPH_3 = 8'h79;
  localparam seg_t GLYPH_4 = 8'h33;
  localparam seg_t GLYPH_5 = 8'h5B;
  localparam seg_t GLYPH_6 = 8'h5F;
  localparam seg_t GLYPH_7 = 8'h70;
  localparam seg_t GLYPH_8 = 8'h7F;
  localparam seg_t GLYPH_9 = 8'h7B;
  localparam seg_t GLYPH_A = 8'h77;
  localparam seg_t GLYPH_B = 8'h1F;
  localparam seg_t GLYPH_C = 8'h4E;
  localparam seg_t GLYPH_D = 8'h3D;
  localparam seg_t GLYPH_E = 8'h4F;
  localparam seg_t GLYPH_F = 8'h47;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph-to-nibble lookup for one digit; glyph_ok drops for unknown
// patterns and, when CHECK_DP is set, for a lit decimal point.
module seg7_glyph_decode
  import seg7_pkg::*;
#(
  parameter bit CHECK_DP = 1'b0
) (
  input  seg_t       pattern,
  output logic [3:0] nibble,
  output logic       glyph_ok
);

  logic known;

  always_comb begin
    nibble = 4'h0;
    known  = 1'b1;
    case (pattern[6:0])
      GLYPH_0[6:0]: nibble = 4'h0;
      GLYPH_1[6:0]: nibble = 4'h1;
      GLYPH_2[6:0]: nibble = 4'h2;
      GLYPH_3[6:0]: nibble = 4'h3;
      GLYPH_4[6:0]: nibble = 4'h4;
      GLYPH_5[6:0]: nibble = 4'h5;
      GLYPH_6[6:0]: nibble = 4'h6;
      GLYPH_7[6:0]: nibble = 4'h7;
      GLYPH_8[6:0]: nibble = 4'h8;
      GLYPH_9[6:0]: nibble = 4'h9;
      GLYPH_A[6:0]: nibble = 4'hA;
      GLYPH_B[6:0]: nibble = 4'hB;
      GLYPH_C[6:0]: nibble = 4'hC;
      GLYPH_D[6:0]: nibble = 4'hD;
      GLYPH_E[6:0]: nibble = 4'hE;
      GLYPH_F[6:0]: nibble = 4'hF;
      default:      known  = 1'b0;
    endcase
  end

  assign glyph_ok = known && (!CHECK_DP || !pattern[SEG_DP]);

endmodule

// File: rtl/seg7_to_bin.sv
// Two-digit 7-segment bus to byte decoder with stability filter and valid/ready output.
// Build option SEG7_ACTIVE_LOW_EN inverts both segment inputs (common-anode buses).
module seg7_to_bin
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter bit CHECK_DP      = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_seg1,
  input  logic [7:0] in_seg2,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       out_valid,
  output logic       err_invalid,
  output logic       err_overrun
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(STABLE_CYCLES - 1);

  logic [15:0]      in_word;
  logic [15:0]      sample_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             armed_reg;
  logic [7:0]       byte_reg;
  logic             valid_reg;
  logic             invalid_reg;
  logic             overrun_reg;

  logic             match;
  logic             fire;
  logic [1:0]       digit_ok;
  logic [1:0][3:0]  digit_nib;
  logic             pair_ok;

`ifdef SEG7_ACTIVE_LOW_EN
  assign in_word = ~{in_seg2, in_seg1};
`else
  assign in_word = {in_seg2, in_seg1};
`endif

  // Decode from the sample register: it equals the inputs whenever fire is high.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_digit
      seg7_glyph_decode #(
        .CHECK_DP (CHECK_DP)
      ) u_decode (
        .pattern  (sample_reg[gi*8 +: 8]),
        .nibble   (digit_nib[gi]),
        .glyph_ok (digit_ok[gi])
      );
    end
  endgenerate

  assign match   = (in_word == sample_reg);
  assign fire    = match && (cnt_reg == CNT_FIRE) && armed_reg;
  assign pair_ok = &digit_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_reg <= '0;
      cnt_reg    <= '0;
      armed_reg  <= 1'b1;
    end else begin
      sample_reg <= in_word;
      if (!match) begin
        cnt_reg   <= '0;
        armed_reg <= 1'b1;
      end else begin
        if (cnt_reg != CNT_MAX) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
        if (fire) begin
          armed_reg <= 1'b0;
        end
      end
    end
  end

  // A decode on an accepting edge reloads the byte and keeps valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_reg    <= 8'h00;
      valid_reg   <= 1'b0;
      invalid_reg <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      invalid_reg <= fire && !pair_ok;
      overrun_reg <= fire && pair_ok && valid_reg && !out_ready;
      if (fire && pair_ok) begin
        byte_reg  <= {digit_nib[1], digit_nib[0]};
        valid_reg <= 1'b1;
      end else if (valid_reg && out_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign out_byte    = byte_reg;
  assign out_valid   = valid_reg;
  assign err_invalid = invalid_reg;
  assign err_overrun = overrun_reg;

endmodule

// File: tb/tb_seg7_to_bin.sv
// Self-checking bench for seg7_to_bin: directed scenarios then random segment streams,
// checked against a run-length reference model (two DUTs: CHECK_DP=0 and CHECK_DP=1).
module tb_seg7_to_bin;

  localparam int S = 4;
`ifdef SEG7_ACTIVE_LOW_EN
  localparam logic [15:0] INV = 16'hFFFF;
`else
  localparam logic [15:0] INV = 16'h0000;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_seg1 = 8'h00;
  logic [7:0] in_seg2 = 8'h00;
  logic       out_ready = 1'b0;
  logic [7:0] out_byte, out_byte_dp;
  logic       out_valid, out_valid_dp;
  logic       err_invalid, err_invalid_dp;
  logic       err_overrun, err_overrun_dp;

  always #5 clk = ~clk;

  seg7_to_bin #(.STABLE_CYCLES(S), .CHECK_DP(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_seg1(in_seg1), .in_seg2(in_seg2),
    .out_ready(out_ready), .out_byte(out_byte), .out_valid(out_valid),
    .err_invalid(err_invalid), .err_overrun(err_overrun)
  );

  seg7_to_bin #(.STABLE_CYCLES(S), .CHECK_DP(1'b1)) dut_dp (
    .clk(clk), .rst_n(rst_n), .in_seg1(in_seg1), .in_seg2(in_seg2),
    .out_ready(out_ready), .out_byte(out_byte_dp), .out_valid(out_valid_dp),
    .err_invalid(err_invalid_dp), .err_overrun(err_overrun_dp)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Reference model: glyph list, a run length of identical samples, per-DUT output state.
  logic [6:0] gtab [16];
  logic [15:0] m_r;
  int          m_run;
  logic        m_valid [2];
  logic [7:0]  m_byte  [2];
  logic        m_inv   [2];
  logic        m_ovr   [2];

  function automatic int glyph_value(input logic [6:0] p);
    for (int i = 0; i < 16; i++) begin
      if (gtab[i] == p) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_r = 16'h0000;
    m_run = 0;
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 1'b0; m_byte[k] = 8'h00; m_inv[k] = 1'b0; m_ovr[k] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic [15:0] raw, input logic rdy);
    logic [15:0] w;
    bit same, fire, ok;
    int lo, hi;
    w = raw ^ INV;
    same = (w == m_r);
    fire = same && (m_run + 1 == S);
    m_run = same ? m_run + 1 : 0;
    m_r = w;
    lo = glyph_value(w[6:0]);
    hi = glyph_value(w[14:8]);
    for (int k = 0; k < 2; k++) begin
      ok = (lo >= 0) && (hi >= 0) && (k == 0 || (w[7] == 1'b0 && w[15] == 1'b0));
      m_inv[k] = fire && !ok;
      m_ovr[k] = fire && ok && m_valid[k] && !rdy;
      if (k == 0 && m_valid[k] && rdy)
        $display("txn accept byte=%02h", m_byte[k]);
      if (fire && ok) begin
        m_byte[k]  = 8'(hi * 16 + lo);
        m_valid[k] = 1'b1;
      end else if (m_valid[k] && rdy) begin
        m_valid[k] = 1'b0;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_valid"},    {15'd0, out_valid},      {15'd0, m_valid[0]});
    check({tag, "_byte"},     {8'd0, out_byte},        {8'd0, m_byte[0]});
    check({tag, "_inv"},      {15'd0, err_invalid},    {15'd0, m_inv[0]});
    check({tag, "_ovr"},      {15'd0, err_overrun},    {15'd0, m_ovr[0]});
    check({tag, "_dp_valid"}, {15'd0, out_valid_dp},   {15'd0, m_valid[1]});
    check({tag, "_dp_byte"},  {8'd0, out_byte_dp},     {8'd0, m_byte[1]});
    check({tag, "_dp_inv"},   {15'd0, err_invalid_dp}, {15'd0, m_inv[1]});
    check({tag, "_dp_ovr"},   {15'd0, err_overrun_dp}, {15'd0, m_ovr[1]});
  endtask

  // One clock: drive logical patterns (pins inverted in the active-low build), then check.
  task automatic tick(input logic [7:0] s1, input logic [7:0] s2, input logic rdy, input string tag);
    logic [15:0] raw;
    raw = {s2, s1} ^ INV;
    in_seg1 = raw[7:0];
    in_seg2 = raw[15:8];
    out_ready = rdy;
    model_edge(raw, rdy);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic hold(input logic [7:0] s1, input logic [7:0] s2, input logic rdy, input int n, input string tag);
    for (int i = 0; i < n; i++) tick(s1, s2, rdy, tag);
  endtask

  initial begin
    gtab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic decode and acceptance; held pattern must not re-emit.
    hold(8'h30, 8'h7E, 1'b0, 4, "p1_wait");
    check("p1_wait_valid", {15'd0, out_valid}, 16'd0);
    tick(8'h30, 8'h7E, 1'b0, "p1_emit");
    check("p1_valid", {15'd0, out_valid}, 16'd1);
    check("p1_byte", {8'd0, out_byte}, 16'h01);
    tick(8'h30, 8'h7E, 1'b1, "p1_acc");
    check("p1_acc_valid", {15'd0, out_valid}, 16'd0);
    hold(8'h30, 8'h7E, 1'b1, 4, "p1_hold");
    check("p1_hold_valid", {15'd0, out_valid}, 16'd0);

    // Short glitch leaves pending data untouched.
    hold(8'h47, 8'h1F, 1'b0, 5, "p2");
    check("p2_byte", {8'd0, out_byte}, 16'hBF);
    hold(8'h7F, 8'h7F, 1'b0, 2, "p2_glitch");
    hold(8'h47, 8'h1F, 1'b0, 2, "p2_back");
    check("p2_back_byte", {8'd0, out_byte}, 16'hBF);
    check("p2_back_inv", {15'd0, err_invalid}, 16'd0);
    tick(8'h47, 8'h1F, 1'b1, "p2_acc");

    // Unknown glyph and dp handling.
    hold(8'h00, 8'h7E, 1'b0, 5, "p3");
    check("p3_inv", {15'd0, err_invalid}, 16'd1);
    check("p3_valid", {15'd0, out_valid}, 16'd0);
    hold(8'hFE, 8'h7E, 1'b0, 5, "p3_dp");
    check("p3_dp_inv", {15'd0, err_invalid_dp}, 16'd1);
    check("p3_nodp_valid", {15'd0, out_valid}, 16'd1);
    check("p3_nodp_byte", {8'd0, out_byte}, 16'h00);
    tick(8'hFE, 8'h7E, 1'b1, "p3_acc");

    // Overrun, then decode coinciding with acceptance.
    hold(8'h30, 8'h7E, 1'b0, 5, "p4_first");
    hold(8'h6D, 8'h79, 1'b0, 5, "p4");
    check("p4_byte", {8'd0, out_byte}, 16'h32);
    check("p4_ovr", {15'd0, err_overrun}, 16'd1);
    check("p4_valid", {15'd0, out_valid}, 16'd1);
    hold(8'h33, 8'h5B, 1'b0, 4, "p5_wait");
    tick(8'h33, 8'h5B, 1'b1, "p5");
    check("p5_byte", {8'd0, out_byte}, 16'h54);
    check("p5_valid", {15'd0, out_valid}, 16'd1);
    check("p5_ovr", {15'd0, err_overrun}, 16'd0);
    tick(8'h33, 8'h5B, 1'b1, "p5_acc");

    // Asynchronous reset mid-window with a pending byte.
    hold(8'h7F, 8'h7F, 1'b0, 5, "p6_pend");
    check("p6_pend_byte", {8'd0, out_byte}, 16'h88);
    hold(8'h30, 8'h7E, 1'b0, 3, "p6_part");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("p6_rst");
    check("p6_rst_valid", {15'd0, out_valid}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hold(8'h30, 8'h7E, 1'b0, 4, "p6_again");
    check("p6_again_wait", {15'd0, out_valid}, 16'd0);
    tick(8'h30, 8'h7E, 1'b0, "p6_emit");
    check("p6_emit_byte", {8'd0, out_byte}, 16'h01);

    // Random segment streams.
    for (int seg = 0; seg < 300; seg++) begin
      logic [7:0] a, b;
      int kind, n;
      kind = $urandom_range(0, 9);
      a = {1'b0, gtab[$urandom_range(0, 15)]};
      b = {1'b0, gtab[$urandom_range(0, 15)]};
      if (kind == 0) a = 8'($urandom);
      else if (kind == 1) b[7] = 1'b1;
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++)
        tick(a, b, ($urandom_range(0, 2) == 0), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
